// File: rtl/queue_display_ctrl_pkg.sv
// Shared types, constants and BCD helper for the ticket-queue display controller.
package queue_pkg;

    // Width of one BCD digit as seen by the seven-segment decoders.
    localparam int BCD_W = 4;

    // Digit code the decoders render with all segments off.
    localparam logic [BCD_W-1:0] BLANK_CODE = 4'hF;

    // Queue occupancy states.
    typedef enum logic [1:0] {
        EMPTY,
        WAITING,
        FULL
    } state_t;

    // Two-digit BCD increment. Units 9 carries into tens, and 99 wraps to 00.
    function automatic logic [2*BCD_W-1:0] bcd_inc2(input logic [2*BCD_W-1:0] v);
        logic [BCD_W-1:0] units;
        logic [BCD_W-1:0] tens;
        units = v[BCD_W-1:0];
        tens  = v[2*BCD_W-1:BCD_W];
        if (units == 4'd9) begin
            units = 4'd0;
            if (tens == 4'd9) begin
                tens = 4'd0;
            end else begin
                tens = tens + 4'd1;
            end
        end else begin
            units = units + 4'd1;
        end
        return {tens, units};
    endfunction

endpackage

// File: rtl/queue_display_ctrl_key_conditioner.sv
// Push-button conditioner: two-flop synchronizer, level debounce and a
// one-cycle pulse on each accepted press (accepted level going 1 -> 0).
module key_conditioner #(
    parameter int DEBOUNCE_CYC = 500000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic key_n,
    output logic press
);

    localparam int CNT_W = (DEBOUNCE_CYC > 1) ? $clog2(DEBOUNCE_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYC - 1);

    logic [1:0]       sync;
    logic             stable;
    logic [CNT_W-1:0] cnt;

    // Bring the asynchronous key into the clk domain.
    // NOTE: synchronizer and accepted level reset to "pressed" so a key held
    // through reset must first be seen released before it can count as a press.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync <= 2'b00;
        end else begin
            sync <= {sync[0], key_n};
        end
    end

    // Accept a new level only after it has been stable for DEBOUNCE_CYC cycles.
    // NOTE: sequential state uses non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stable <= 1'b0;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            press <= 1'b0;
            if (sync[1] == stable) begin
                cnt <= '0;
            end else if (cnt == CNT_LAST) begin
                cnt    <= '0;
                stable <= sync[1];
                press  <= ~sync[1];
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/queue_display_ctrl.sv
// Bank ticket-queue controller: counts issued and served tickets in BCD,
// tracks the waiting count and drives the six display digit codes.
module queue_display_ctrl
    import queue_pkg::*;
#(
    parameter int CAPACITY     = 9,
    parameter int DEBOUNCE_CYC = 500000,
    parameter int BLINK_DIV    = 25000000
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               arrive_key_n,
    input  logic               serve_key_n,
    output logic [2*BCD_W-1:0] ticket_bcd,
    output logic [2*BCD_W-1:0] serving_bcd,
    output logic [BCD_W-1:0]   count_bcd,
    output logic [BCD_W-1:0]   blank_bcd,
    output logic               full,
    output logic               empty
);

    localparam int               BLINK_W    = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;
    localparam logic [BLINK_W-1:0] BLINK_LAST = BLINK_W'(BLINK_DIV - 1);
    localparam logic [BCD_W-1:0]   CAP_CODE   = BCD_W'(CAPACITY);
    localparam logic [2*BCD_W-1:0] BLANK_PAIR = {BLANK_CODE, BLANK_CODE};

    logic arrive_p;
    logic serve_p;

    state_t             state;
    logic [BCD_W-1:0]   count;
    logic [2*BCD_W-1:0] ticket;
    logic [2*BCD_W-1:0] serving;
    logic               ticket_seen;
    logic               serving_seen;
    logic [BLINK_W-1:0] blink_cnt;
    logic               blink_hidden;

    logic               do_arrive;
    logic               do_serve;
    logic [BCD_W-1:0]   count_nxt;
    state_t             state_nxt;
    logic [2*BCD_W-1:0] ticket_nxt;
    logic [2*BCD_W-1:0] serving_nxt;
    logic [BLINK_W-1:0] blink_cnt_nxt;
    logic               blink_hidden_nxt;

    key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_arrive_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (arrive_key_n),
        .press (arrive_p)
    );

    key_conditioner #(.DEBOUNCE_CYC(DEBOUNCE_CYC)) u_serve_key (
        .clk   (clk),
        .rst_n (rst_n),
        .key_n (serve_key_n),
        .press (serve_p)
    );

    assign blank_bcd = BLANK_CODE;

    // Decide which key events take effect and derive the next counters, state and blink phase.
    // NOTE: every signal gets a default at the top so no path leaves it unassigned,
    // which would otherwise infer a latch.
    always_comb begin
        do_arrive        = arrive_p && ((state != FULL) || serve_p);
        do_serve         = serve_p && (state != EMPTY);
        count_nxt        = count;
        ticket_nxt       = ticket;
        serving_nxt      = serving;
        blink_cnt_nxt    = '0;
        blink_hidden_nxt = 1'b0;

        if (do_arrive) begin
            ticket_nxt = bcd_inc2(ticket);
        end
        if (do_serve) begin
            serving_nxt = bcd_inc2(serving);
        end
        if (do_arrive && !do_serve) begin
            count_nxt = count + 4'd1;
        end else if (!do_arrive && do_serve) begin
            count_nxt = count - 4'd1;
        end

        if (count_nxt == 4'd0) begin
            state_nxt = EMPTY;
        end else if (count_nxt == CAP_CODE) begin
            state_nxt = FULL;
        end else begin
            state_nxt = WAITING;
        end

        // Blink runs only while staying in FULL; entering FULL restarts it visible.
        if ((state_nxt == FULL) && (state == FULL)) begin
            if (blink_cnt == BLINK_LAST) begin
                blink_cnt_nxt    = '0;
                blink_hidden_nxt = ~blink_hidden;
            end else begin
                blink_cnt_nxt    = blink_cnt + BLINK_W'(1);
                blink_hidden_nxt = blink_hidden;
            end
        end
    end

    // Register queue state and all display outputs from the next-state values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= EMPTY;
            count        <= '0;
            ticket       <= '0;
            serving      <= '0;
            ticket_seen  <= 1'b0;
            serving_seen <= 1'b0;
            blink_cnt    <= '0;
            blink_hidden <= 1'b0;
            ticket_bcd   <= BLANK_PAIR;
            serving_bcd  <= BLANK_PAIR;
            count_bcd    <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
        end else begin
            state        <= state_nxt;
            count        <= count_nxt;
            ticket       <= ticket_nxt;
            serving      <= serving_nxt;
            ticket_seen  <= ticket_seen || do_arrive;
            serving_seen <= serving_seen || do_serve;
            blink_cnt    <= blink_cnt_nxt;
            blink_hidden <= blink_hidden_nxt;
            ticket_bcd   <= (ticket_seen || do_arrive) ? ticket_nxt : BLANK_PAIR;
            serving_bcd  <= (serving_seen || do_serve) ? serving_nxt : BLANK_PAIR;
            count_bcd    <= blink_hidden_nxt ? BLANK_CODE : count_nxt;
            full         <= (state_nxt == FULL);
            empty        <= (state_nxt == EMPTY);
        end
    end

endmodule

// File: doc/queue_display_ctrl.md
Name: queue_display_ctrl

Overview:
Ticket-queue controller for the bank-queue board (DE10-Lite, 50 MHz).
- Conditions the two push-button keys (customer arrive, teller serve).
- Keeps BCD counters for last-issued ticket, now-serving ticket and waiting count.
- Drives 4-bit BCD digit codes to the six sevenBehavioral decoders (HEX5..HEX0).
- Blanks a digit by driving code 4'hF, which the decoder renders all-off.

Parameters:
CAPACITY, 9, max customers waiting (1..9, single BCD digit)
DEBOUNCE_CYC, 500000, cycles a key level must be stable before it is accepted (10 ms)
BLINK_DIV, 25000000, cycles per blink half-period in FULL (0.5 s)

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
arrive_key_n  in  1  raw key, active-low, asynchronous
serve_key_n  in  1  raw key, active-low, asynchronous
ticket_bcd  out  8  {tens,units} of last issued ticket -> HEX5/HEX4
serving_bcd  out  8  {tens,units} of ticket now served -> HEX3/HEX2
count_bcd  out  4  customers waiting -> HEX0
blank_bcd  out  4  constant 4'hF -> HEX1
full  out  1  count == CAPACITY
empty  out  1  count == 0

Behaviour:
- Clock and reset: single clock clk; reset is asynchronous, active-low (rst_n), applied to all flops.
- Reset values:
  - ticket=00, serving=00, count=0, state=EMPTY, blink phase=visible.
  - ticket_bcd=8'hFF, serving_bcd=8'hFF (blank until first issue/serve).
  - count_bcd=4'h0, full=0, empty=1.
- Key conditioning, per key:
  - 2-flop synchronizer.
  - Debounce counter: the accepted level changes only after DEBOUNCE_CYC consecutive cycles at the new level.
  - The accepted level's 1->0 transition produces a 1-cycle press pulse. Release produces nothing.
- State machine: EMPTY (count=0), WAITING (0<count<CAPACITY), FULL (count=CAPACITY).
- Arrive pulse:
  - If not FULL: ticket increments in BCD (99 wraps to 00), count+1.
  - In FULL: ignored.
- Serve pulse:
  - If not EMPTY: serving increments in BCD (99 wraps to 00), count-1.
  - In EMPTY: ignored.
- Simultaneous arrive and serve pulses, same cycle:
  - WAITING or FULL: both apply, count unchanged, state unchanged.
  - EMPTY: arrive applies, serve ignored, count=1.
- BCD arithmetic: units 9->0 carries into tens; tens 9 with carry -> 0. Digits never hold 10-15.
- Latency: pulse in cycle N -> counters, state, full/empty and digit outputs all updated at the clock edge ending cycle N. Outputs are register-driven with no combinational path from the keys.
- Display:
  - ticket_bcd shows blank until the first arrive is accepted, then the value (00 after wrap is shown, not blank).
  - serving_bcd follows the same rule on the first accepted serve.
- Blink:
  - In FULL, a counter toggles blink phase every BLINK_DIV cycles; count_bcd alternates CAPACITY / 4'hF.
  - Entering FULL starts at phase visible with the counter cleared.
  - Outside FULL the counter is held at 0 and count_bcd shows count.
- Reset mid-operation (including mid-debounce or mid-blink): all state returns to reset values immediately. A key held through reset release is accepted only as a new press after it is released and re-pressed.

Decomposition:
- Package queue_pkg holds:
  - state enum {EMPTY, WAITING, FULL}
  - BLANK_CODE = 4'hF
  - BCD digit width (4)
  - a BCD two-digit increment function
- Sub-module key_conditioner (sync + debounce + falling-edge pulse, parameter DEBOUNCE_CYC), instantiated twice.

Test Plan (DEBOUNCE_CYC=4, BLINK_DIV=8, CAPACITY=3):
- Reset, then idle -> ticket_bcd=FF, serving_bcd=FF, count_bcd=0, empty=1, full=0.
- Serve press while empty -> no change. Three arrive presses -> ticket_bcd=03, count_bcd=3, full=1; count_bcd alternates 3/F every 8 cycles, starting with 3.
- Fourth arrive while full -> ticket stays 03. Serve -> serving_bcd=01, count_bcd=2, blinking stops, full=0.
- Arrive and serve pulses in the same cycle at count=2 -> ticket+1, serving+1, count stays 2. Same at count=0 -> count=1, serving unchanged.
- Key bounce of 3-cycle glitches -> no pulse. A 4-cycle-stable low -> exactly one pulse. Holding the key -> no repeat.
- Drive ticket to 99 (CAPACITY=9 build, interleaved serves), then arrive -> ticket_bcd=00 displayed. Assert rst_n mid-blink -> outputs return to reset values asynchronously.
